grid_game_ctrl: RTL and testbench

Parametrised N×N, K-in-a-row two-player game engine: the next generation of the fixed 3×3 tic-tac-toe game core. It takes synchronized `Btn`/`SelBtn` levels from the existing `sync_btn` instances and maintains the board, cursor and turn. It checks for a win serially from the last placed cell and exports the packed board to the colour/VGA path. Everything runs in the 25 MHz pixel clock domain.

---
 rtl/grid_game_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_grid_game_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl: N x N board, K-in-a-row two-player game engine.
// Button edges move the cursor and place marks. After each placement a serial
// win check probes outward from the last placed cell.
// Optional feature macro: GRID_CURSOR_SKIP_EN. When defined, btn_next searches
// forward for the next empty cell instead of stepping the cursor by one.
module grid_game_ctrl #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_next_i,
  input  logic                   btn_sel_i,
  output logic [2*N*N-1:0]       cells_o,
  output logic [$clog2(N*N)-1:0] cursor_o,
  output logic                   turn_o,
  output logic [1:0]             winner_o,
  output logic                   busy_o,
  output logic                   game_over_o
);
  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int RC_W  = $clog2(N);
  localparam int CNT_W = $clog2(CELLS + 1);
  localparam int POS_W = IDX_W + 2 * RC_W;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef GRID_CURSOR_SKIP_EN
  localparam logic [1:0] ST_SEARCH = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [2*CELLS-1:0] cells_q, cells_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [RC_W-1:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic             busy_q, busy_d;
  logic             game_over_q, game_over_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic             next_hist_q, sel_hist_q;
  logic [RC_W-1:0]  last_row_q, last_row_d, last_col_q, last_col_d;
  logic [2:0]       dir_q, dir_d;      // 0..3 = direction, 4 = decide cycle
  logic             sense_q, sense_d;  // 0 = outward in + sense, 1 = - sense
  logic [3:0]       step_q, step_d;    // distance from the last placed cell
  logic             alive_q, alive_d;  // run in the current sense not yet broken
  logic [3:0]       run_q, run_d;
  logic             win_q, win_d;
`ifdef GRID_CURSOR_SKIP_EN
  logic [POS_W-1:0] srch_pos_q, srch_pos_d;
`endif

  logic             next_edge, sel_edge;
  logic [1:0]       mark;
  logic [1:0]       cell_arr [CELLS];
  logic [POS_W-1:0] cur_pos;
  int               dr, dc, pr, pc;
  logic             in_bounds, probe_hit;
  logic [IDX_W-1:0] probe_idx;
  logic [3:0]       run_inc;

  assign next_edge = btn_next_i & ~next_hist_q;
  assign sel_edge  = btn_sel_i & ~sel_hist_q;
  assign mark      = turn_q ? 2'b10 : 2'b01;
  assign cur_pos   = {cursor_q, cur_row_q, cur_col_q};

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    assign cell_arr[gi] = cells_q[2*gi +: 2];
  end

  // Step a {index,row,col} position forward by one cell, wrapping at the end.
  function automatic logic [POS_W-1:0] pos_adv(input logic [POS_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [RC_W-1:0]  r, c;
    {idx, r, c} = p;
    if (c == RC_W'(N - 1)) begin
      c = '0;
      r = (r == RC_W'(N - 1)) ? '0 : r + 1'b1;
    end else begin
      c = c + 1'b1;
    end
    idx = (idx == IDX_W'(CELLS - 1)) ? '0 : idx + 1'b1;
    return {idx, r, c};
  endfunction

  // Probe address: row/col of the last cell offset along the current direction.
  always_comb begin
    dr = 0;
    dc = 0;
    case (dir_q)
      3'd0:    begin dr = 0; dc = 1;  end
      3'd1:    begin dr = 1; dc = 0;  end
      3'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (sense_q) begin
      dr = -dr;
      dc = -dc;
    end
    pr        = int'(last_row_q) + dr * int'(step_q);
    pc        = int'(last_col_q) + dc * int'(step_q);
    in_bounds = (pr >= 0) && (pr < N) && (pc >= 0) && (pc < N);
    probe_idx = in_bounds ? IDX_W'(pr * N + pc) : '0;
    probe_hit = alive_q && in_bounds && (cell_arr[probe_idx] == mark);
    run_inc   = run_q + {3'b000, probe_hit};
  end

  // Next-state logic for play, serial win check, game over and cursor search.
  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    cursor_d    = cursor_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    busy_d      = busy_q;
    game_over_d = game_over_q;
    moves_d     = moves_q;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
    dir_d       = dir_q;
    sense_d     = sense_q;
    step_d      = step_q;
    alive_d     = alive_q;
    run_d       = run_q;
    win_d       = win_q;
`ifdef GRID_CURSOR_SKIP_EN
    srch_pos_d  = srch_pos_q;
`endif
    case (state_q)
      ST_PLAY: begin
        // A select wins over a simultaneous next; selecting a full cell does nothing.
        if (sel_edge) begin
          if (cell_arr[cursor_q] == 2'b00) begin
            cells_d[{cursor_q, 1'b0} +: 2] = mark;
            last_row_d = cur_row_q;
            last_col_d = cur_col_q;
            moves_d    = moves_q + 1'b1;
            dir_d      = 3'd0;
            sense_d    = 1'b0;
            step_d     = 4'd1;
            alive_d    = 1'b1;
            run_d      = 4'd1;
            win_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_CHECK;
          end
        end else if (next_edge) begin
`ifdef GRID_CURSOR_SKIP_EN
          srch_pos_d = pos_adv(cur_pos);
          busy_d     = 1'b1;
          state_d    = ST_SEARCH;
`else
          {cursor_d, cur_row_d, cur_col_d} = pos_adv(cur_pos);
`endif
        end
      end
      ST_CHECK: begin
        if (dir_q == 3'd4) begin
          busy_d = 1'b0;
          if (win_q) begin
            winner_d    = mark;
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else if (moves_q == CNT_W'(CELLS)) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_PLAY;
          end
        end else if (step_q == 4'(K - 1)) begin
          if (!sense_q) begin
            sense_d = 1'b1;
            step_d  = 4'd1;
            alive_d = 1'b1;
            run_d   = run_inc;
          end else begin
            if (run_inc >= 4'(K)) win_d = 1'b1;
            dir_d   = dir_q + 3'd1;
            sense_d = 1'b0;
            step_d  = 4'd1;
            alive_d = 1'b1;
            run_d   = 4'd1;
          end
        end else begin
          step_d  = step_q + 4'd1;
          alive_d = probe_hit;
          run_d   = run_inc;
        end
      end
      ST_DONE: begin
        if (sel_edge) begin
          cells_d     = '0;
          cursor_d    = '0;
          cur_row_d   = '0;
          cur_col_d   = '0;
          turn_d      = 1'b0;
          winner_d    = 2'b00;
          moves_d     = '0;
          game_over_d = 1'b0;
          state_d     = ST_PLAY;
        end
      end
`ifdef GRID_CURSOR_SKIP_EN
      ST_SEARCH: begin
        // PLAY never has a full board, so an empty cell is always found.
        if (cell_arr[srch_pos_q[POS_W-1 -: IDX_W]] == 2'b00) begin
          {cursor_d, cur_row_d, cur_col_d} = srch_pos_q;
          busy_d  = 1'b0;
          state_d = ST_PLAY;
        end else begin
          srch_pos_d = pos_adv(srch_pos_q);
        end
      end
`endif
      default: state_d = ST_PLAY;
    endcase
  end

  // State registers; button history resets high so a held button gives no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      cells_q     <= '0;
      cursor_q    <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      turn_q      <= 1'b0;
      winner_q    <= 2'b00;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      moves_q     <= '0;
      next_hist_q <= 1'b1;
      sel_hist_q  <= 1'b1;
      last_row_q  <= '0;
      last_col_q  <= '0;
      dir_q       <= 3'd0;
      sense_q     <= 1'b0;
      step_q      <= 4'd1;
      alive_q     <= 1'b0;
      run_q       <= 4'd1;
      win_q       <= 1'b0;
`ifdef GRID_CURSOR_SKIP_EN
      srch_pos_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      cursor_q    <= cursor_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      moves_q     <= moves_d;
      next_hist_q <= btn_next_i;
      sel_hist_q  <= btn_sel_i;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      dir_q       <= dir_d;
      sense_q     <= sense_d;
      step_q      <= step_d;
      alive_q     <= alive_d;
      run_q       <= run_d;
      win_q       <= win_d;
`ifdef GRID_CURSOR_SKIP_EN
      srch_pos_q  <= srch_pos_d;
`endif
    end
  end

  assign cells_o     = cells_q;
  assign cursor_o    = cursor_q;
  assign turn_o      = turn_q;
  assign winner_o    = winner_q;
  assign busy_o      = busy_q;
  assign game_over_o = game_over_q;
endmodule

// File: tb/tb_grid_game_ctrl.sv
// Testbench for grid_game_ctrl: a 3x3 and a 4x4 (K=3) instance, scenario tasks
// plus random play checked against a whole-board reference model.
module tb_grid_game_ctrl;
  localparam int KWIN = 3;

  logic clk = 1'b0;
  logic rst;
  logic bn3, bs3, bn4, bs4;
  logic [17:0] cells3;
  logic [31:0] cells4;
  logic [3:0]  cur3, cur4;
  logic        turn3, turn4, busy3, busy4, go3, go4;
  logic [1:0]  win3, win4;

  int errors = 0;
  int checks = 0;

  grid_game_ctrl #(.N(3), .K(3)) dut3 (
    .clk(clk), .rst(rst), .btn_next_i(bn3), .btn_sel_i(bs3),
    .cells_o(cells3), .cursor_o(cur3), .turn_o(turn3), .winner_o(win3),
    .busy_o(busy3), .game_over_o(go3));

  grid_game_ctrl #(.N(4), .K(3)) dut4 (
    .clk(clk), .rst(rst), .btn_next_i(bn4), .btn_sel_i(bs4),
    .cells_o(cells4), .cursor_o(cur4), .turn_o(turn4), .winner_o(win4),
    .busy_o(busy4), .game_over_o(go4));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mb [2][16];
  int mcur [2];
  int mturn [2];
  int mwin [2];
  int mover [2];
  int mmoves [2];

  function automatic int side(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic logic [31:0] o_cells(input int d);
    return (d == 0) ? {14'b0, cells3} : cells4;
  endfunction
  function automatic logic [3:0] o_cur(input int d);
    return (d == 0) ? cur3 : cur4;
  endfunction
  function automatic logic o_turn(input int d);
    return (d == 0) ? turn3 : turn4;
  endfunction
  function automatic logic [1:0] o_win(input int d);
    return (d == 0) ? win3 : win4;
  endfunction
  function automatic logic o_busy(input int d);
    return (d == 0) ? busy3 : busy4;
  endfunction
  function automatic logic o_go(input int d);
    return (d == 0) ? go3 : go4;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mb[d][i] = 0;
      mcur[d] = 0; mturn[d] = 0; mwin[d] = 0; mover[d] = 0; mmoves[d] = 0;
    end
  endtask

  // Scan the whole board for any KWIN-long line of mark m.
  function automatic bit m_has_win(input int d, input int m);
    int n, rr, cc;
    bit ok;
    int vr [4];
    int vc [4];
    vr[0] = 0; vc[0] = 1;
    vr[1] = 1; vc[1] = 0;
    vr[2] = 1; vc[2] = 1;
    vr[3] = 1; vc[3] = -1;
    n = side(d);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int v = 0; v < 4; v++) begin
          ok = 1'b1;
          for (int j = 0; j < KWIN; j++) begin
            rr = r + vr[v] * j;
            cc = c + vc[v] * j;
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (mb[d][rr*n+cc] != m) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_cells(input int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < side(d) * side(d); i++) v[2*i +: 2] = 2'(mb[d][i]);
    return v;
  endfunction

  task automatic m_act(input int d, input bit nx, input bit sl, output bit placed);
    int n, mk;
    n = side(d);
    placed = 1'b0;
    if (sl) begin
      if (mover[d] != 0) begin
        for (int i = 0; i < 16; i++) mb[d][i] = 0;
        mcur[d] = 0; mturn[d] = 0; mwin[d] = 0; mover[d] = 0; mmoves[d] = 0;
      end else if (mb[d][mcur[d]] == 0) begin
        mk = mturn[d] + 1;
        mb[d][mcur[d]] = mk;
        mmoves[d]++;
        placed = 1'b1;
        if (m_has_win(d, mk)) begin mwin[d] = mk; mover[d] = 1; end
        else if (mmoves[d] == n * n) begin mwin[d] = 3; mover[d] = 1; end
        else mturn[d] = 1 - mturn[d];
      end
    end else if (nx && mover[d] == 0) begin
      mcur[d] = (mcur[d] + 1) % (n * n);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic act(input int d, input bit nx, input bit sl);
    @(posedge clk); #1;
    if (d == 0) begin bn3 = nx; bs3 = sl; end
    else        begin bn4 = nx; bs4 = sl; end
    @(posedge clk); #1;
    bn3 = 1'b0; bs3 = 1'b0; bn4 = 1'b0; bs4 = 1'b0;
  endtask

  task automatic wait_idle(input int d, output int cyc);
    cyc = 0;
    while (o_busy(d) && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // One transaction: drive edges, update the model, wait out any check.
  task automatic step(input int d, input bit nx, input bit sl, output bit placed, output int cyc);
    act(d, nx, sl);
    m_act(d, nx, sl, placed);
    wait_idle(d, cyc);
    $display("txn dut%0d next=%0b sel=%0b cursor=%0d turn=%0b winner=%0d over=%0b busy_cycles=%0d",
             d, nx, sl, o_cur(d), o_turn(d), o_win(d), o_go(d), cyc);
  endtask

  task automatic goto(input int d, input int target);
    bit p;
    int c;
    int g;
    g = 0;
    while (mcur[d] != target && g < 20) begin
      step(d, 1'b1, 1'b0, p, c);
      g++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bn3 = 1'b1; bs3 = 1'b1; bn4 = 1'b1; bs4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cells(d) !== 32'h0) begin
        errors++; $display("FAIL reset_cells dut%0d got=%h want=0", d, o_cells(d));
      end
      checks++;
      if (o_cur(d) !== 4'h0) begin
        errors++; $display("FAIL reset_cursor dut%0d got=%0d want=0", d, o_cur(d));
      end
      checks++;
      if ({o_turn(d), o_win(d), o_busy(d), o_go(d)} !== 5'b0) begin
        errors++; $display("FAIL reset_flags dut%0d got=%b want=00000", d,
                           {o_turn(d), o_win(d), o_busy(d), o_go(d)});
      end
    end
    bn3 = 1'b0; bs3 = 1'b0; bn4 = 1'b0; bs4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_row_win();
    int seq [5] = '{0, 3, 1, 4, 2};
    bit p;
    int cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto(0, seq[i]);
      step(0, 1'b0, 1'b1, p, cyc);
      checks++;
      if (cyc !== 17) begin
        errors++; $display("FAIL row_busy_len move%0d got=%0d want=17", i, cyc);
      end
    end
    checks++;
    if (win3 !== 2'b01 || go3 !== 1'b1) begin
      errors++; $display("FAIL row_winner got=%b/%b want=01/1", win3, go3);
    end
    checks++;
    if (cells3 !== 18'b00_00_00_00_10_10_01_01_01) begin
      errors++; $display("FAIL row_cells got=%b want=%b", cells3, 18'b00_00_00_00_10_10_01_01_01);
    end
  endtask

  task automatic test_occupied();
    bit p;
    int cyc;
    int busy_seen;
    do_reset();
    step(0, 1'b0, 1'b1, p, cyc);
    step(0, 1'b0, 1'b1, p, cyc);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy3) busy_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_seen != 0 || cyc != 0) begin
      errors++; $display("FAIL occupied_busy got=%0d want=0", busy_seen + cyc);
    end
    checks++;
    if (cells3 !== 18'h00001 || turn3 !== 1'b1) begin
      errors++; $display("FAIL occupied_state got=%h/%b want=00001/1", cells3, turn3);
    end
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    bit p;
    int cyc;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      goto(0, seq[i]);
      step(0, 1'b0, 1'b1, p, cyc);
    end
    checks++;
    if (win3 !== 2'b11 || go3 !== 1'b1) begin
      errors++; $display("FAIL draw_winner got=%b/%b want=11/1", win3, go3);
    end
    checks++;
    if (cur3 !== 4'd8) begin
      errors++; $display("FAIL draw_cursor got=%0d want=8", cur3);
    end
    step(0, 1'b0, 1'b1, p, cyc);
    checks++;
    if (cells3 !== 18'h0 || turn3 !== 1'b0 || cur3 !== 4'd0 || win3 !== 2'b00 || go3 !== 1'b0) begin
      errors++; $display("FAIL draw_clear got=cells %h turn %b cur %0d win %b over %b want=all zero",
                         cells3, turn3, cur3, win3, go3);
    end
  endtask

  task automatic test_cursor_wrap();
    bit p;
    int cyc;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, 1'b1, 1'b0, p, cyc);
      checks++;
      if (cur3 !== 4'((i + 1) % 9)) begin
        errors++; $display("FAIL wrap_cursor step%0d got=%0d want=%0d", i, cur3, (i + 1) % 9);
      end
    end
    step(0, 1'b1, 1'b0, p, cyc);
    step(0, 1'b1, 1'b0, p, cyc);
    step(0, 1'b1, 1'b1, p, cyc);
    checks++;
    if (cur3 !== 4'd2 || cells3 !== 18'h00010 || turn3 !== 1'b1 || cyc !== 17) begin
      errors++; $display("FAIL both_edges got=cur %0d cells %h turn %b busy %0d want=cur 2 cells 00010 turn 1 busy 17",
                         cur3, cells3, turn3, cyc);
    end
  endtask

  task automatic test_anti_diag();
    int seq [5] = '{2, 0, 5, 1, 8};
    bit p;
    int cyc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto(1, seq[i]);
      step(1, 1'b0, 1'b1, p, cyc);
    end
    checks++;
    if (win4 !== 2'b01 || go4 !== 1'b1) begin
      errors++; $display("FAIL anti_winner got=%b/%b want=01/1", win4, go4);
    end
    checks++;
    if (cells4 !== 32'h0001041A) begin
      errors++; $display("FAIL anti_cells got=%h want=0001041a", cells4);
    end
  endtask

  task automatic test_rst_mid_check();
    do_reset();
    act(1, 1'b0, 1'b1);
    checks++;
    if (busy4 !== 1'b1 || cells4 !== 32'h1) begin
      errors++; $display("FAIL midrst_setup got=busy %b cells %h want=busy 1 cells 1", busy4, cells4);
    end
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (cells4 !== 32'h0 || cur4 !== 4'h0 || {turn4, win4, busy4, go4} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs got=cells %h cur %0d flags %b want=all zero",
                         cells4, cur4, {turn4, win4, busy4, go4});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic test_random();
    bit p, nx, sl;
    int cyc, r;
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int it = 0; it < 60; it++) begin
        r  = int'($urandom_range(0, 99));
        nx = (r < 55);
        sl = (r >= 45);
        step(d, nx, sl, p, cyc);
        if (p) begin
          checks++;
          if (cyc !== 17) begin
            errors++; $display("FAIL rnd_busy dut%0d it%0d got=%0d want=17", d, it, cyc);
          end
        end
        checks++;
        if (o_cells(d) !== m_cells(d)) begin
          errors++; $display("FAIL rnd_cells dut%0d it%0d got=%h want=%h", d, it, o_cells(d), m_cells(d));
        end
        checks++;
        if (o_cur(d) !== 4'(mcur[d])) begin
          errors++; $display("FAIL rnd_cursor dut%0d it%0d got=%0d want=%0d", d, it, o_cur(d), mcur[d]);
        end
        checks++;
        if (o_turn(d) !== 1'(mturn[d]) || o_win(d) !== 2'(mwin[d]) || o_go(d) !== 1'(mover[d])) begin
          errors++; $display("FAIL rnd_status dut%0d it%0d got=%b%b%b want=%b%b%b", d, it,
                             o_turn(d), o_win(d), o_go(d), 1'(mturn[d]), 2'(mwin[d]), 1'(mover[d]));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bn3 = 1'b0; bs3 = 1'b0; bn4 = 1'b0; bs4 = 1'b0;
    test_reset();
    test_row_win();
    test_occupied();
    test_draw();
    test_cursor_wrap();
    test_anti_diag();
    test_rst_mid_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=no finish want=finish");
    $fatal(1, "timeout");
  end
endmodule
